// File: rtl/shift_frame_ctrl.sv
// Sequencer for an external parallel-load shift register: accepts a word over valid/ready,
// loads it, shifts it out one bit per clock as a framed stream, then clears the register.
module shift_frame_ctrl #(
  parameter int unsigned SHIFT_WIDTH = 8,
  parameter bit          FILL_BIT    = 1'b0
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   in_valid,
  input  logic [SHIFT_WIDTH-1:0] in_data,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [SHIFT_WIDTH-1:0] sr_data,
  output logic                   sr_load,
  output logic                   sr_enable,
  output logic                   sr_sclr,
  output logic                   sr_sset,
  output logic                   sr_shiftin,
  input  logic                   sr_shiftout,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  localparam int unsigned CntW = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SHIFT_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StFinish} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [SHIFT_WIDTH-1:0] data_q;
  logic                   abort_q;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A handshake takes priority over abort, which is ignored here.
          if (in_valid) begin
            data_q  <= in_data;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          cnt_q <= '0;
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= StFinish;
          end else begin
            state_q <= StShift;
          end
        end
        StShift: begin
          cnt_q <= cnt_q + 1'b1;
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= StFinish;
          end else if (cnt_q == CntLast) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          abort_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore decode: only ser_out depends on an input (the register's serial output).
  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign sr_data    = data_q;
  assign sr_load    = (state_q == StLoad);
  assign sr_enable  = (state_q != StIdle);
  assign sr_sclr    = (state_q == StFinish);
  assign sr_sset    = 1'b0;
  assign sr_shiftin = FILL_BIT;
  assign ser_valid  = (state_q == StShift);
  assign ser_out    = ser_valid & sr_shiftout;
  assign done       = (state_q == StFinish) & ~abort_q;
  assign aborted    = (state_q == StFinish) & abort_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl with a behavioural shift register model and a serial-bit scoreboard.
module tb_shift_frame_ctrl;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         aclr_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         abort = 1'b0;
  logic [W-1:0] sr_data;
  logic         sr_load, sr_enable, sr_sclr, sr_sset, sr_shiftin, sr_shiftout;
  logic         ser_out, ser_valid, busy, done, aborted;

  shift_frame_ctrl #(.SHIFT_WIDTH(W), .FILL_BIT(1'b0)) dut (
    .clock      (clock),
    .aclr_n     (aclr_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .abort      (abort),
    .sr_data    (sr_data),
    .sr_load    (sr_load),
    .sr_enable  (sr_enable),
    .sr_sclr    (sr_sclr),
    .sr_sset    (sr_sset),
    .sr_shiftin (sr_shiftin),
    .sr_shiftout(sr_shiftout),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clock = ~clock;

  // Shift register model; not reset by aclr_n, matching the external part.
  bit           dir_left = 1'b1;
  logic [W-1:0] sr_q = '0;
  always @(posedge clock) begin
    if (sr_enable) begin
      if (sr_sclr)      sr_q <= '0;
      else if (sr_load) sr_q <= sr_data;
      else if (dir_left) sr_q <= {sr_q[W-2:0], sr_shiftin};
      else               sr_q <= {sr_shiftin, sr_q[W-1:1]};
    end
  end
  assign sr_shiftout = dir_left ? sr_q[W-1] : sr_q[0];

  int n_tests = 0;
  int n_fail = 0;
  int bits_seen = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bits(input logic [W-1:0] data, input bit left, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(left ? data[W-1-i] : data[i]);
  endtask

  // Scoreboard: pop one expected bit per valid serial cycle.
  always @(negedge clock) begin
    if (aclr_n) begin
      if (ser_valid) begin
        bits_seen++;
        chk("ser_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("ser_bit", 32'(ser_out), 32'(exp_q.pop_front()));
      end else begin
        chk("ser_gated", 32'(ser_out), 0);
      end
      if (done)    done_cnt++;
      if (aborted) abort_cnt++;
    end
  end

  typedef struct {
    logic [W-1:0] data;
    bit           left;
    int           abort_idx;  // -2 none, -1 in LOAD, k in SHIFT cycle k
    bit           idle_abort;
    int           exp_bits;
    bit           exp_done;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int fin;
    int bits0;
    dir_left = v.left;
    bits0 = bits_seen;
    @(negedge clock);
    chk("ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = v.data;
    abort    = v.idle_abort;
    push_bits(v.data, v.left, v.exp_bits);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    in_data  = W'($urandom);
    if (v.abort_idx == -1)     fin = 2;
    else if (v.abort_idx >= 0) fin = 3 + v.abort_idx;
    else                       fin = W + 2;
    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clock);
      abort = ((v.abort_idx == -1 && c == 1) || (v.abort_idx >= 0 && c == 2 + v.abort_idx));
      if (c == 1) begin
        chk("load_pulse", 32'(sr_load), 1);
        chk("load_data", 32'(sr_data), 32'(v.data));
        chk("load_not_ready", 32'(in_ready), 0);
      end
      if (c == fin) begin
        chk("finish_done", 32'(done), 32'(v.exp_done));
        chk("finish_aborted", 32'(aborted), 32'(!v.exp_done));
        chk("finish_sclr", 32'({sr_sclr, sr_enable}), 3);
      end
      if (c == fin + 1) begin
        chk("idle_ready", 32'({in_ready, busy}), 2);
        chk("reg_cleared", 32'(sr_q), 0);
      end
    end
    abort = 1'b0;
    chk("bit_count", 32'(bits_seen - bits0), 32'(v.exp_bits));
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   n;
    int   d0;
    int   a0;
    bit   seen;
    vecs[0] = '{8'hCC, 1'b1, -2, 1'b0, 8, 1'b1};
    vecs[1] = '{8'hCC, 1'b0, -2, 1'b0, 8, 1'b1};
    vecs[2] = '{8'hA5, 1'b1,  2, 1'b0, 3, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, -1, 1'b0, 0, 1'b0};
    vecs[4] = '{8'h81, 1'b1,  7, 1'b0, 8, 1'b0};
    vecs[5] = '{8'h96, 1'b1, -2, 1'b1, 8, 1'b1};
    vecs[6] = '{8'h5A, 1'b0, -2, 1'b0, 8, 1'b1};

    #3;
    chk("rst_ready_busy", 32'({in_ready, busy}), 2);
    chk("rst_sr_ctl", 32'({sr_load, sr_enable, sr_sclr, sr_sset, sr_shiftin}), 0);
    chk("rst_sr_data", 32'(sr_data), 0);
    chk("rst_ser_pulses", 32'({ser_valid, ser_out, done, aborted}), 0);
    @(negedge clock);
    aclr_n = 1'b1;

    foreach (vecs[i]) run_frame(vecs[i]);

    // Back-to-back frames with in_valid held high.
    dir_left = 1'b1;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    push_bits(8'hA5, 1'b1, W);
    @(posedge clock);
    #1;
    in_data = 8'h3C;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 40);
    chk("b2b_spacing", 32'(n), 11);
    push_bits(8'h3C, 1'b1, W);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      seen = done;
    end
    chk("b2b_second_done", 32'(seen), 1);
    @(negedge clock);
    chk("b2b_queue_drained", 32'(exp_q.size()), 0);

    // in_valid while busy must not start or latch a new word.
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'hF0;
    push_bits(8'hF0, 1'b1, W);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      if (c == 3) begin
        in_valid = 1'b1;
        in_data  = 8'h0F;
      end
      if (c == 9) in_valid = 1'b0;
      if (c == 5) chk("busy_not_ready", 32'(in_ready), 0);
      if (c == 8) chk("busy_no_latch", 32'(sr_data), 32'(8'hF0));
      if (c == 11) chk("busy_no_restart", 32'({in_ready, busy}), 2);
    end
    chk("busy_queue_drained", 32'(exp_q.size()), 0);

    // Reset in the middle of SHIFT.
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    push_bits(8'hFF, 1'b1, W);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    d0 = done_cnt;
    a0 = abort_cnt;
    #1;
    aclr_n = 1'b0;
    #1;
    chk("midrst_state", 32'({busy, in_ready, sr_enable, ser_valid}), 4'b0100);
    exp_q.delete();
    repeat (2) @(negedge clock);
    aclr_n = 1'b1;
    repeat (12) @(negedge clock);
    chk("midrst_no_pulse", 32'({done_cnt - d0, abort_cnt - a0}), 0);
    chk("midrst_idle", 32'({in_ready, busy}), 2);

    run_frame(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
